dffram_2p: RTL

Parametrised successor of the team's single-port 512x32 DFFRAM. One read/write port (port 0, byte-enabled) plus one independent read-only port (port 1). It has selectable read-during-write semantics, a collision flag and an optional hardware clear sequencer that zeroes the array after reset. It sits as the shared vertex/face buffer between the subdivision datapath (port 0) and the output/readback logic (port 1). It has no file I/O.

---
 rtl/dffram_2p.sv | 86 ++++++++
 1 files changed

// File: rtl/dffram_2p.sv
// rtl/dffram_2p.sv - two-port (read/write + read-only) byte-enabled DFF RAM with post-reset clear sequencer
module dffram_2p #(
  parameter int A_WIDTH    = 9,
  parameter int D_WIDTH    = 32,
  parameter int RD_MODE    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   EN0,
  input  logic [D_WIDTH/8-1:0]   WE0,
  input  logic [A_WIDTH-1:0]     A0,
  input  logic [D_WIDTH-1:0]     Di0,
  output logic [D_WIDTH-1:0]     Do0,
  input  logic                   EN1,
  input  logic [A_WIDTH-1:0]     A1,
  output logic [D_WIDTH-1:0]     Do1,
  output logic                   BUSY,
  output logic                   COLL
);

  localparam int NUM_WORDS = 2**A_WIDTH;
  localparam int NB        = D_WIDTH/8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [0:0] ST_RESET = (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(NUM_WORDS - 1);

  logic [D_WIDTH-1:0] mem [NUM_WORDS];
  logic [0:0]         state;
  logic [A_WIDTH-1:0] cnt;
  logic               busy;
  logic               wr0;
  logic               coll_now;
  logic [D_WIDTH-1:0] old0;
  logic [D_WIDTH-1:0] old1;
  logic [D_WIDTH-1:0] merged0;

  assign busy     = (state == ST_CLEAR);
  assign BUSY     = busy;
  assign old0     = mem[A0];
  assign old1     = mem[A1];
  assign wr0      = EN0 && (|WE0);
  assign coll_now = wr0 && EN1 && (A0 == A1);

  // Word as it will look after this cycle's port 0 write; feeds the write-first read path.
  always_comb begin
    merged0 = old0;
    for (int i = 0; i < NB; i++) begin
      if (WE0[i]) merged0[8*i +: 8] = Di0[8*i +: 8];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_RESET;
      cnt   <= '0;
      Do0   <= '0;
      Do1   <= '0;
      COLL  <= 1'b0;
    end else if (busy) begin
      cnt  <= cnt + 1'b1;
      if (cnt == LAST_ADDR) state <= ST_IDLE;
      Do0  <= '0;
      Do1  <= '0;
      COLL <= 1'b0;
    end else begin
      Do0  <= !EN0 ? '0 : ((RD_MODE != 0) ? merged0 : old0);
      Do1  <= !EN1 ? '0 : ((RD_MODE != 0 && coll_now) ? merged0 : old1);
      COLL <= coll_now;
    end
  end

  // The array has no reset; port writes are held off while reset is asserted.
  always_ff @(posedge CLK) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else if (RST_N && EN0) begin
      for (int i = 0; i < NB; i++) begin
        if (WE0[i]) mem[A0][8*i +: 8] <= Di0[8*i +: 8];
      end
    end
  end

endmodule
